// File: rtl/pmem_line_model_pkg.sv
// Shared types and helpers for the line-granular physical-memory responder.
// Holds the line mask type, the responder FSM state type and the saturating counter step.
package pmem_line_model_pkg;

  localparam int unsigned LC3B_LINE_BYTES = 32;

  typedef logic [LC3B_LINE_BYTES-1:0] lc3b_line_mask;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } pmem_state_t;

  localparam logic [15:0] CountMax = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CountMax) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: registered byte-masked write, combinational read, cleared by async reset.
module pmem_line_array #(
  parameter int unsigned LINE_BYTES  = 32,
  parameter int unsigned DEPTH_LINES = 64,
  localparam int unsigned IdxW       = $clog2(DEPTH_LINES)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IdxW-1:0]         widx_i,
  input  logic [LINE_BYTES*8-1:0] wdata_i,
  input  logic [LINE_BYTES-1:0]   wmask_i,
  input  logic [IdxW-1:0]         ridx_i,
  output logic [LINE_BYTES*8-1:0] rdata_o
);

  logic [LINE_BYTES*8-1:0] mem_q [DEPTH_LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH_LINES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < int'(LINE_BYTES); b++) begin
        if (wmask_i[b]) begin
          mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/pmem_line_model.sv
// Physical-memory line responder with per-direction latency, stall injection,
// byte-masked writes, sticky protocol-error flag and saturating transaction counters.
module pmem_line_model
  import pmem_line_model_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LINE_BYTES  = 32,
  parameter int unsigned DEPTH_LINES = 64,
  parameter int unsigned RD_LATENCY  = 4,
  parameter int unsigned WR_LATENCY  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       address,
  input  logic [LINE_BYTES*8-1:0] wdata,
  input  logic [LINE_BYTES-1:0]   wmask,
  input  logic                    stall,
  output logic                    resp,
  output logic [LINE_BYTES*8-1:0] rdata,
  output logic                    busy,
  output logic                    protocol_err,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);

  localparam int unsigned OfsW   = $clog2(LINE_BYTES);
  localparam int unsigned IdxW   = $clog2(DEPTH_LINES);
  localparam int unsigned MaxLat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  pmem_state_t             state_q, state_d;
  logic                    op_rd_q, op_rd_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [LINE_BYTES*8-1:0] wdata_q, wdata_d;
  logic [LINE_BYTES-1:0]   wmask_q, wmask_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [LINE_BYTES*8-1:0] rdata_q, rdata_d;
  logic                    perr_q, perr_d;
  logic [15:0]             rd_cnt_q, rd_cnt_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;

  logic                    mem_we;
  logic [LINE_BYTES*8-1:0] mem_rdata;
  logic [IdxW-1:0]         req_idx;
  logic                    own_req;
  logic                    opp_req;

  // Offset and upper address bits are intentionally don't-care; lines wrap.
  logic unused_addr;
  assign unused_addr = ^address;

  assign req_idx = address[OfsW +: IdxW];
  assign own_req = op_rd_q ? read : write;
  assign opp_req = op_rd_q ? write : read;

  always_comb begin
    state_d  = state_q;
    op_rd_d  = op_rd_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    perr_d   = perr_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;

    case (state_q)
      StIdle: begin
        if (read && write) begin
          perr_d = 1'b1;
        end else if (read || write) begin
          op_rd_d = read;
          idx_d   = req_idx;
          wdata_d = wdata;
          wmask_d = wmask;
          cnt_d   = read ? CntW'(RD_LATENCY - 1) : CntW'(WR_LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (opp_req) begin
          perr_d = 1'b1;
        end
        if (!own_req) begin
          state_d = StIdle;
        end else if (!stall) begin
          if (cnt_q == '0) begin
            state_d = StResp;
            if (op_rd_q) begin
              rdata_d = mem_rdata;
            end else begin
              mem_we = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StResp: begin
        state_d = StIdle;
        if (op_rd_q) begin
          rd_cnt_d = sat_inc16(rd_cnt_q);
        end else begin
          wr_cnt_d = sat_inc16(wr_cnt_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_rd_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_rd_q  <= op_rd_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      perr_q   <= perr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  pmem_line_array #(
    .LINE_BYTES (LINE_BYTES),
    .DEPTH_LINES(DEPTH_LINES)
  ) u_array (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (mem_we),
    .widx_i (idx_q),
    .wdata_i(wdata_q),
    .wmask_i(wmask_q),
    .ridx_i (idx_q),
    .rdata_o(mem_rdata)
  );

  assign resp         = (state_q == StResp);
  assign busy         = (state_q != StIdle);
  assign rdata        = rdata_q;
  assign protocol_err = perr_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_pmem_line_model.sv
// Scoreboarded random/directed bench for pmem_line_model against a line-array reference model.
module tb_pmem_line_model;
  import pmem_line_model_pkg::*;

  localparam int RdLat = 4;
  localparam int WrLat = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read, write, stall;
  logic [15:0]   address;
  logic [255:0]  wdata;
  lc3b_line_mask wmask;
  logic          resp, busy, protocol_err;
  logic [255:0]  rdata;
  logic [15:0]   rd_count, wr_count;

  pmem_line_model #(
    .ADDR_W     (16),
    .LINE_BYTES (32),
    .DEPTH_LINES(64),
    .RD_LATENCY (RdLat),
    .WR_LATENCY (WrLat)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read        (read),
    .write       (write),
    .address     (address),
    .wdata       (wdata),
    .wmask       (wmask),
    .stall       (stall),
    .resp        (resp),
    .rdata       (rdata),
    .busy        (busy),
    .protocol_err(protocol_err),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [255:0] data;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  logic [255:0] mline [64];
  logic [255:0] last_rd;
  int           m_rd, m_wr;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mline[i] = '0;
    last_rd = '0;
    m_rd = 0;
    m_wr = 0;
  endtask

  // Monitor: every resp must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp === 1'b1) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 256'(resp), 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", 256'(cyc), 256'(e.cyc));
        chk("resp_rdata", rdata, e.data);
      end
    end
  end

  // One full transaction; called just after a falling edge.
  task automatic txn(input bit is_rd, input logic [15:0] addr, input logic [255:0] wd,
                     input logic [31:0] wm, input int ns, input bit poke_opp);
    int   idx, a, t;
    exp_t e;
    idx = (int'(addr) / 32) % 64;
    read = is_rd;
    write = !is_rd;
    address = addr;
    wdata = wd;
    wmask = wm;
    if (is_rd) begin
      e.data = mline[idx];
    end else begin
      for (int b = 0; b < 32; b++) if (wm[b]) mline[idx][b*8 +: 8] = wd[b*8 +: 8];
      e.data = last_rd;
    end
    @(posedge clk);
    #1;
    a = cyc;
    e.cyc = a + (is_rd ? RdLat : WrLat) + ns;
    sb.push_back(e);
    chk("busy_after_accept", 256'(busy), 256'd1);
    for (int i = 0; i < ns; i++) begin
      @(negedge clk);
      stall = 1'b1;
    end
    if (ns > 0) begin
      @(negedge clk);
      stall = 1'b0;
    end
    if (poke_opp) begin
      @(negedge clk);
      if (is_rd) write = 1'b1; else read = 1'b1;
      @(negedge clk);
      if (is_rd) write = 1'b0; else read = 1'b0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (resp !== 1'b1 && t < 100);
    if (resp !== 1'b1) begin
      chk("txn_timeout", 256'd1, 256'd0);
      sb.delete();
    end
    read = 1'b0;
    write = 1'b0;
    if (is_rd) begin
      last_rd = mline[idx];
      m_rd++;
    end else begin
      m_wr++;
    end
    @(negedge clk);
    chk("rd_count", 256'(rd_count), 256'(m_rd));
    chk("wr_count", 256'(wr_count), 256'(m_wr));
    chk("busy_idle", 256'(busy), 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] rw;
    logic [15:0]  ra;
    bit           seen;
    rst_n = 1'b0;
    read = 1'b0;
    write = 1'b0;
    stall = 1'b0;
    address = '0;
    wdata = '0;
    wmask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_resp", 256'(resp), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_perr", 256'(protocol_err), 256'd0);
    chk("rst_rd_count", 256'(rd_count), 256'd0);
    chk("rst_wr_count", 256'(wr_count), 256'd0);
    chk("rst_rdata", rdata, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b1, 16'h2340, '0, '0, 0, 1'b0);
    txn(1'b0, 16'h0000, {32{8'hA5}}, 32'h0000_00FF, 0, 1'b0);
    txn(1'b1, 16'h0000, '0, '0, 0, 1'b0);
    chk("masked_merge", rdata, {192'd0, {8{8'hA5}}});

    for (int k = 0; k < 8; k++) rw[k*32 +: 32] = $urandom;
    txn(1'b0, 16'h0040, rw, 32'hFFFF_FFFF, 0, 1'b0);
    txn(1'b1, 16'h1040, '0, '0, 0, 1'b0);
    chk("index_wrap", rdata, rw);
    txn(1'b1, 16'h0040, '0, '0, 3, 1'b0);

    // Both requests in IDLE: error flag, no accept.
    read = 1'b1;
    write = 1'b1;
    repeat (3) @(negedge clk);
    chk("both_perr", 256'(protocol_err), 256'd1);
    chk("both_no_busy", 256'(busy), 256'd0);
    read = 1'b0;
    write = 1'b0;
    repeat (2) @(negedge clk);
    chk("perr_sticky", 256'(protocol_err), 256'd1);

    // Read dropped while BUSY aborts silently.
    read = 1'b1;
    address = 16'h0040;
    @(posedge clk);
    #1;
    @(negedge clk);
    read = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp === 1'b1) seen = 1'b1;
    end
    chk("abort_no_resp", 256'(seen), 256'd0);
    chk("abort_rd_count", 256'(rd_count), 256'(m_rd));
    chk("abort_busy", 256'(busy), 256'd0);

    // Reset while BUSY clears everything immediately, storage included.
    for (int k = 0; k < 8; k++) rw[k*32 +: 32] = $urandom | 32'h1;
    txn(1'b0, 16'h0080, rw, 32'hFFFF_FFFF, 0, 1'b0);
    read = 1'b1;
    address = 16'h0080;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp", 256'(resp), 256'd0);
    chk("midrst_busy", 256'(busy), 256'd0);
    chk("midrst_perr", 256'(protocol_err), 256'd0);
    chk("midrst_wr_count", 256'(wr_count), 256'd0);
    read = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b1, 16'h0080, '0, '0, 0, 1'b0);
    chk("post_rst_line", rdata, 256'd0);

    // Opposite request during BUSY flags an error but the read completes.
    txn(1'b1, 16'h0100, '0, '0, 0, 1'b1);
    chk("opp_perr", 256'(protocol_err), 256'd1);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++) rw[k*32 +: 32] = $urandom;
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[10:5] = 6'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), ra, rw, $urandom, $urandom_range(0, 3), 1'b0);
    end

    chk("sb_drained", 256'(sb.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_line_model.md
Name: pmem_line_model

Overview:
- Parametrised successor to the single-latency physical-memory responder used under mpnc and the L2 in our benches.
- Serves 32-byte line reads and writes on the standard pmem_read/pmem_write/pmem_resp handshake.
- Adds configurable per-direction latency, a stall-injection input, byte-masked writes, protocol-error detection, and transaction counters.
- Sits below the cache hierarchy in every bench. Also synthesisable as an FPGA-side memory stub.

Parameters:
- ADDR_W, 16, byte-address width.
- LINE_BYTES, 32, bytes per line. Power of two, at least 2.
- DEPTH_LINES, 64, lines of storage. Power of two. Index = address[OFS_W +: IDX_W]; upper bits are ignored, so addresses wrap.
- RD_LATENCY, 4, cycles from accept edge to resp for reads. Must be at least 1.
- WR_LATENCY, 4, cycles from accept edge to resp for writes. Must be at least 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read  in  1  line read request; held until resp.
- write  in  1  line write request; held until resp.
- address  in  ADDR_W  byte address; offset bits are ignored.
- wdata  in  LINE_BYTES*8  write line.
- wmask  in  LINE_BYTES  per-byte write enable; bit i enables byte i.
- stall  in  1  while high, freezes the latency counter.
- resp  out  1  one-cycle completion pulse.
- rdata  out  LINE_BYTES*8  read line; valid during resp.
- busy  out  1  high in BUSY and RESP.
- protocol_err  out  1  sticky error flag.
- rd_count  out  16  completed reads, saturating.
- wr_count  out  16  completed writes, saturating.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - resp=0, busy=0, protocol_err=0, rd_count=0, wr_count=0.
  - rdata=0, latency counter=0.
  - All storage lines cleared to 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - read^write sampled high: accept. Latch op, index, wdata and wmask; load cnt with RD_LATENCY-1 or WR_LATENCY-1; go to BUSY.
  - read&write both high: set protocol_err, no accept, stay in IDLE.
- BUSY:
  - Request dropped (the latched op's signal low): abort. Go to IDLE; no resp, no storage update, no count.
  - stall=1: cnt holds.
  - stall=0 and cnt==0: go to RESP and apply the operation.
    - Read: rdata <= line[index].
    - Write: line[index] bytes with wmask=1 <= wdata bytes; other bytes unchanged.
  - stall=0 and cnt!=0: cnt decrements.
  - Address, wdata or wmask change after accept: ignored; latched values are used.
  - Opposite request raised while BUSY: set protocol_err; the transaction continues.
- RESP: resp=1 for exactly one cycle. Increment rd_count or wr_count, saturating at 16'hFFFF. Go to IDLE.
- Latency with no stall:
  - Accept at edge T; resp is high in the cycle following edge T+LATENCY.
  - Each stalled cycle adds one cycle.
- Back-to-back: a request still high in the cycle after resp is accepted again. The requester must drop it on the cycle after resp.
- rdata holds its last read value outside resp. Writes never change rdata.
- Read-after-write to the same line returns the masked-merged data.
- Reset mid-transaction: immediate abort to IDLE and all reset values; no resp.

Decomposition:
- lc3b_types additions:
  - lc3b_line_mask (logic [31:0]).
  - pmem_state_t enum {IDLE, BUSY, RESP}.
  - constant LC3B_LINE_BYTES=32.
- One sub-module, pmem_line_array: DEPTH_LINES x LINE_BYTES*8 storage with registered byte-masked write, async read, and async-reset clear.
- The FSM, counter and statistics live in the top level.

Test Plan:
- Reset then read 16'h2340, RD_LATENCY=4, stall=0: resp in the cycle after accept-edge+4; rdata=0; rd_count=1.
- Write 16'h0000 with wdata bytes=8'hA5 and wmask=32'h0000_00FF, then read 16'h0000: bytes 0-7=A5, bytes 8-31=00; wr_count=1, rd_count=1.
- Write to 16'h0040 then read 16'h1040 with DEPTH_LINES=64: the write data is returned (index wrap).
- Read with stall held 3 cycles mid-BUSY: resp delayed exactly 3 cycles vs the no-stall run.
- read=write=1 in IDLE: protocol_err=1 and stays 1; no resp. Separately, drop read in BUSY: no resp, rd_count unchanged.
- Assert rst_n=0 in BUSY: resp=0, busy=0 at once; after release, a new read of the prior line returns 0.
